// File: rtl/rom_arb_mp.sv
// Shared single-port ROM serving NC read channels through a round-robin request/ack arbiter.
// Latency: grant edge + 1 enabled cycle (OREG=0) or + 2 (OREG=1); one read in total per enabled cycle.
// Backpressure: none downstream; requesters hold rd/adr until ack, and clk_en=0 freezes all state.
module rom_arb_mp #(
  parameter     MI   = "",
  parameter int DW   = 8,
  parameter int MD   = 1024,
  parameter int AW   = $clog2(MD),
  parameter int NC   = 4,
  parameter int OREG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [NC-1:0]    rd,
  input  logic [NC*AW-1:0] adr,
  output logic [NC-1:0]    ack,
  output logic [NC-1:0]    vld,
  output logic [NC*DW-1:0] dat_r
);

  localparam int PW = (NC > 1) ? $clog2(NC) : 1;

  logic [DW-1:0] mem [0:MD-1];

  logic [PW-1:0] ptr;
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [AW-1:0] gnt_adr;
  logic          gnt_in_rng;

  // First requester at or after ptr, wrapping modulo NC.
  always_comb begin
    int            c;
    logic [PW-1:0] ci;
    ack     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = 0;
    ci      = '0;
    if (rst_n && clk_en) begin
      for (int i = 0; i < NC; i++) begin
        c = int'(ptr) + i;
        if (c >= NC) c = c - NC;
        ci = PW'(c);
        if (!gnt_any && rd[ci]) begin
          gnt_any = 1'b1;
          gnt_idx = ci;
        end
      end
      if (gnt_any) ack[gnt_idx] = 1'b1;
    end
  end

  assign gnt_adr    = adr[int'(gnt_idx)*AW +: AW];
  assign gnt_in_rng = (32'(gnt_adr) < 32'(MD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clk_en && gnt_any) begin
      ptr <= (gnt_idx == PW'(NC-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  logic          s1_vld;
  logic [PW-1:0] s1_tag;
  logic [DW-1:0] s1_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_tag <= '0;
    end else if (clk_en) begin
      s1_vld <= gnt_any;
      if (gnt_any) s1_tag <= gnt_idx;
    end
  end

  // Array read register carries no reset so it can map onto a block RAM output latch.
  always_ff @(posedge clk) begin
    if (clk_en && gnt_any) s1_dat <= gnt_in_rng ? mem[gnt_adr] : '0;
  end

  logic          l_vld;
  logic [PW-1:0] l_tag;
  logic [DW-1:0] l_dat;

  if (OREG != 0) begin : g_oreg
    logic          s2_vld;
    logic [PW-1:0] s2_tag;
    logic [DW-1:0] s2_dat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_vld <= 1'b0;
        s2_tag <= '0;
        s2_dat <= '0;
      end else if (clk_en) begin
        s2_vld <= s1_vld;
        s2_tag <= s1_tag;
        s2_dat <= s1_dat;
      end
    end

    assign l_vld = s2_vld;
    assign l_tag = s2_tag;
    assign l_dat = s2_dat;
  end else begin : g_noreg
    assign l_vld = s1_vld;
    assign l_tag = s1_tag;
    assign l_dat = s1_dat;
  end

  // Only the tagged channel's slice moves; the others keep their last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      dat_r <= '0;
    end else if (clk_en) begin
      vld <= '0;
      if (l_vld) begin
        vld[l_tag]                    <= 1'b1;
        dat_r[int'(l_tag)*DW +: DW]   <= l_dat;
      end
    end
  end

endmodule
